mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mips_mem_pkg.sv | 25 ++
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_lane_fmt.sv | 58 +++++
 rtl/mem_access_unit.sv | 111 +++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types for the CPU data-memory access unit: access sizes and FSM states.
// Purely declarative, no latency or backpressure of its own.
// MEM_ACCESS_ALIGN_CHECK_EN (optional) is consumed by mem_access_unit.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    MEM_B   = 2'b00,
    MEM_H   = 2'b01,
    MEM_W   = 2'b10,
    MEM_RSV = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } mau_state_e;

  // Only a full-word store can skip the read; everything else needs the old word.
  function automatic logic needs_read(input logic wr, input mem_size_e size);
    return !wr || (size != MEM_W);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response and data-memory port bundle for mem_access_unit.
// No latency; req is only honoured when the unit is idle (busy low).
// The slave modport is the unit, master is the CPU/memory side.
interface mem_access_unit_if #(parameter int AW = 10);
  import mips_mem_pkg::*;

  logic            req;
  logic            wr;
  mem_size_e       size;
  logic            sext;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic            busy;
  logic            done;
  logic [31:0]     rdata;
  logic            err;
  logic [AW-1:0]   dm_addr;
  logic            dm_we;
  logic [31:0]     dm_din;
  logic [31:0]     dm_dout;

  modport master (
    output req, wr, size, sext, addr, wdata, dm_dout,
    input  busy, done, rdata, err, dm_addr, dm_we, dm_din
  );

  modport slave (
    input  req, wr, size, sext, addr, wdata, dm_dout,
    output busy, done, rdata, err, dm_addr, dm_we, dm_din
  );

endinterface

// File: rtl/mem_lane_fmt.sv
// Little-endian lane select/extend for loads and lane merge for sub-word stores.
// Purely combinational, zero latency.
// No backpressure; outputs follow inputs.
module mem_lane_fmt
  import mips_mem_pkg::*;
(
  input  mem_size_e   size,
  input  logic        sext,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[7:0];
    case (lane)
      2'd0: byte_v = word[7:0];
      2'd1: byte_v = word[15:8];
      2'd2: byte_v = word[23:16];
      2'd3: byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_val = word;
    merged   = word;
    case (size)
      MEM_B: begin
        load_val = {{24{sext & byte_v[7]}}, byte_v};
        case (lane)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged     = word;
        endcase
      end
      MEM_H: begin
        load_val = {{16{sext & half_v[15]}}, half_v};
        // lane[0] is ignored here, which gives the unchecked misaligned behaviour.
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: begin
        load_val = word;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store sequencer to a single-port word memory; MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned H/W.
// Latency from request cycle to done: load 2, word store 2, sub-word store 3 (read-modify-write); reject err 1.
// No queueing: req is sampled only in IDLE and ignored while busy.
module mem_access_unit #(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus
);
  import mips_mem_pkg::*;

  mau_state_e    state_q, state_d;
  logic [AW+1:0] a_addr;
  logic          a_wr;
  logic          a_sext;
  mem_size_e     a_size;
  logic [31:0]   a_wdata;
  logic [31:0]   word_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          misalign;
  logic          accept;
  logic          reject;
  logic [31:0]   fmt_word;
  logic [31:0]   load_val;
  logic [31:0]   merged;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^bus.addr[31:AW+2];

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misalign = ((bus.size == MEM_H) && bus.addr[0]) ||
                    ((bus.size == MEM_W) && (bus.addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign accept = (state_q == IDLE) && bus.req && (bus.size != MEM_RSV) && !misalign;
  assign reject = (state_q == IDLE) && bus.req && ((bus.size == MEM_RSV) || misalign);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = needs_read(bus.wr, bus.size) ? RD : WR;
      RD:      state_d = a_wr ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are frozen at acceptance so the CPU may change them freely afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_addr  <= '0;
      a_wr    <= 1'b0;
      a_sext  <= 1'b0;
      a_size  <= MEM_B;
      a_wdata <= '0;
    end else if (accept) begin
      a_addr  <= bus.addr[AW+1:0];
      a_wr    <= bus.wr;
      a_sext  <= bus.sext;
      a_size  <= bus.size;
      a_wdata <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= reject;
      if (state_q == RD) begin
        word_q <= bus.dm_dout;
        if (!a_wr) rdata_q <= load_val;
      end
    end
  end

  // Loads format the live memory word in RD; stores merge into the captured word in WR.
  assign fmt_word = (state_q == RD) ? bus.dm_dout : word_q;

  mem_lane_fmt u_lane_fmt (
    .size     (a_size),
    .sext     (a_sext),
    .lane     (a_addr[1:0]),
    .word     (fmt_word),
    .wdata    (a_wdata),
    .load_val (load_val),
    .merged   (merged)
  );

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.err     = err_q;
  assign bus.rdata   = rdata_q;
  assign bus.dm_we   = (state_q == WR);
  assign bus.dm_addr = (state_q != IDLE) ? a_addr[AW+1:2] : '0;
  assign bus.dm_din  = (state_q == WR) ? merged : '0;

endmodule
